// File: rtl/scan_cmd_pkg.sv
// Shared definitions for the scan command engine: command/reply codes,
// FSM state encoding and payload byte-count helpers.
package scan_cmd_pkg;

    localparam logic [7:0] CMD_RST   = "r";
    localparam logic [7:0] CMD_SHIFT = "s";
    localparam logic [7:0] CMD_GET   = "g";
    localparam logic [7:0] CMD_RUN   = "o";
    localparam logic [7:0] CMD_PI    = "e";
    localparam logic [7:0] CMD_PO    = "i";

    localparam logic [7:0] RSP_OK  = "K";
    localparam logic [7:0] RSP_UNK = "?";
    localparam logic [7:0] RSP_TMO = "!";

    typedef enum logic [3:0] {
        IDLE,
        RX_PAYLOAD,
        RST_PULSE,
        SHIFT_SETUP,
        SHIFT_PULSE,
        RUN,
        TX_REQ,
        TX_WAIT_LOW,
        TX_WAIT_HIGH,
        ABORT
    } state_t;

    function automatic int nbytes(input int bits);
        return (bits + 7) / 8;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dut_clk_pulse.sv
// One DUT clock pulse per start: CLK_DIV cycles low, CLK_DIV cycles high,
// then low again with a one-cycle done strobe.
// Ports: clk, rst (sync, active high), start, dut_clk (registered), done.
module dut_clk_pulse #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic dut_clk,
    output logic done
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic          active_q;
    logic          hi_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            cnt_q    <= '0;
            dut_clk  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active_q) begin
                if (start) begin
                    active_q <= 1'b1;
                    hi_q     <= 1'b0;
                    cnt_q    <= CW'(CLK_DIV - 1);
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (!hi_q) begin
                hi_q    <= 1'b1;
                dut_clk <= 1'b1;
                cnt_q   <= CW'(CLK_DIV - 1);
            end else begin
                hi_q     <= 1'b0;
                dut_clk  <= 1'b0;
                active_q <= 1'b0;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_cmd_engine.sv
// UART byte-command scan test controller: load/unload scan chains,
// clock the DUT, force PIs, read POs; every command gets a UART reply.
// Ports: clk/rst, rx byte strobe in, tx start/ready handshake out,
// dut_* test pins (all registered), busy_o while not IDLE.
module scan_cmd_engine
    import scan_cmd_pkg::*;
#(
    parameter int NCHAINS    = 1,
    parameter int CHAIN_LEN  = 16,
    parameter int NPIS       = 8,
    parameter int NPOS       = 8,
    parameter int CLK_DIV    = 2,
    parameter int RX_TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_ready_i,
    output logic               dut_clk_o,
    output logic               dut_rst_o,
    output logic               dut_se_o,
    output logic               dut_tm_o,
    output logic [NCHAINS-1:0] dut_si_o,
    input  logic [NCHAINS-1:0] dut_so_i,
    output logic [NPIS-1:0]    dut_pi_o,
    input  logic [NPOS-1:0]    dut_po_i,
    output logic               busy_o
);

    localparam int SB = nbytes(NCHAINS * CHAIN_LEN);
    localparam int PB = nbytes(NPIS);
    localparam int OB = nbytes(NPOS);
    // Buffer also holds the 16-bit run count and the PI/PO bytes.
    localparam int NB = max_of(max_of(SB, PB), max_of(OB, 2));
    localparam int BW = 8 * NB;
    localparam int IW = $clog2(NB + 1);
    localparam int SW = $clog2(CHAIN_LEN + 1);
    localparam int TW = $clog2(RX_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [BW-1:0]       sbuf_q, sbuf_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       len_q, len_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [SW-1:0]       step_q, step_d;
    logic [15:0]         run_q, run_d;
    logic                txs_q, txs_d;
    logic [7:0]          txd_q, txd_d;
    logic                drst_q, drst_d;
    logic                se_q, se_d;
    logic                tm_q, tm_d;
    logic [NCHAINS-1:0]  si_q, si_d;
    logic [NPIS-1:0]     pi_q, pi_d;

    logic [NCHAINS-1:0]  so_s1, so_s2;
    logic [NPOS-1:0]     po_s1, po_s2;

    logic                pulse_start;
    logic                pulse_done;
    logic                do_reply;
    logic [7:0]          reply_code;
    int                  sbase;

    dut_clk_pulse #(
        .CLK_DIV(CLK_DIV)
    ) u_pulse (
        .clk    (clk),
        .rst    (rst),
        .start  (pulse_start),
        .dut_clk(dut_clk_o),
        .done   (pulse_done)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        sbuf_d      = sbuf_q;
        idx_d       = idx_q;
        len_d       = len_q;
        tmo_d       = tmo_q;
        step_d      = step_q;
        run_d       = run_q;
        txs_d       = txs_q;
        txd_d       = txd_q;
        drst_d      = 1'b0;
        se_d        = se_q;
        tm_d        = tm_q;
        si_d        = si_q;
        pi_d        = pi_q;
        pulse_start = 1'b0;
        do_reply    = 1'b0;
        reply_code  = RSP_OK;
        sbase       = int'(step_q) * NCHAINS;

        unique case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    cmd_d = rx_data_i;
                    idx_d = '0;
                    tmo_d = '0;
                    case (rx_data_i)
                        CMD_RST: begin
                            drst_d      = 1'b1;
                            pulse_start = 1'b1;
                            state_d     = RST_PULSE;
                        end
                        CMD_SHIFT: begin
                            len_d   = IW'(SB);
                            state_d = RX_PAYLOAD;
                        end
                        CMD_RUN: begin
                            len_d   = IW'(2);
                            state_d = RX_PAYLOAD;
                        end
                        CMD_PI: begin
                            len_d   = IW'(PB);
                            state_d = RX_PAYLOAD;
                        end
                        CMD_GET: begin
                            // Cleared so pad bits go out as zero.
                            sbuf_d  = '0;
                            se_d    = 1'b1;
                            tm_d    = 1'b1;
                            step_d  = '0;
                            state_d = SHIFT_SETUP;
                        end
                        CMD_PO: begin
                            sbuf_d           = '0;
                            sbuf_d[NPOS-1:0] = po_s2;
                            len_d            = IW'(OB);
                            state_d          = TX_REQ;
                        end
                        default: begin
                            do_reply   = 1'b1;
                            reply_code = RSP_UNK;
                        end
                    endcase
                end
            end

            RX_PAYLOAD: begin
                if (rx_valid_i) begin
                    sbuf_d[{idx_q, 3'b000} +: 8] = rx_data_i;
                    tmo_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == len_q - IW'(1)) begin
                        idx_d = '0;
                        case (cmd_q)
                            CMD_SHIFT: begin
                                se_d    = 1'b1;
                                tm_d    = 1'b1;
                                step_d  = '0;
                                state_d = SHIFT_SETUP;
                            end
                            CMD_RUN: begin
                                se_d = 1'b0;
                                if (sbuf_d[15:0] == 16'd0) begin
                                    do_reply = 1'b1;
                                end else begin
                                    tm_d        = 1'b0;
                                    run_d       = sbuf_d[15:0];
                                    pulse_start = 1'b1;
                                    state_d     = RUN;
                                end
                            end
                            default: begin
                                pi_d     = sbuf_d[NPIS-1:0];
                                do_reply = 1'b1;
                            end
                        endcase
                    end
                end else if (tmo_q == TW'(RX_TIMEOUT)) begin
                    state_d = ABORT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            RST_PULSE: begin
                drst_d = 1'b1;
                if (pulse_done) begin
                    drst_d   = 1'b0;
                    do_reply = 1'b1;
                end
            end

            SHIFT_SETUP: begin
                // Unload recirculates each captured bit back into the chain.
                if (cmd_q == CMD_GET) begin
                    sbuf_d[sbase +: NCHAINS] = so_s2;
                    si_d                     = so_s2;
                end else begin
                    si_d = sbuf_q[sbase +: NCHAINS];
                end
                pulse_start = 1'b1;
                state_d     = SHIFT_PULSE;
            end

            SHIFT_PULSE: begin
                if (pulse_done) begin
                    step_d = step_q + 1'b1;
                    if (step_q == SW'(CHAIN_LEN - 1)) begin
                        if (cmd_q == CMD_SHIFT) begin
                            se_d     = 1'b0;
                            do_reply = 1'b1;
                        end else begin
                            len_d   = IW'(SB);
                            idx_d   = '0;
                            state_d = TX_REQ;
                        end
                    end else begin
                        state_d = SHIFT_SETUP;
                    end
                end
            end

            RUN: begin
                if (pulse_done) begin
                    if (run_q == 16'd1) begin
                        tm_d     = 1'b1;
                        do_reply = 1'b1;
                    end else begin
                        run_d       = run_q - 16'd1;
                        pulse_start = 1'b1;
                    end
                end
            end

            TX_REQ: begin
                if (tx_ready_i) begin
                    txs_d   = 1'b1;
                    txd_d   = sbuf_q[{idx_q, 3'b000} +: 8];
                    state_d = TX_WAIT_LOW;
                end
            end

            TX_WAIT_LOW: begin
                if (!tx_ready_i) begin
                    txs_d   = 1'b0;
                    state_d = TX_WAIT_HIGH;
                end
            end

            TX_WAIT_HIGH: begin
                if (tx_ready_i) begin
                    if (idx_q == len_q - IW'(1)) begin
                        // Unload keeps se high until the data is out.
                        se_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = TX_REQ;
                    end
                end
            end

            ABORT: begin
                do_reply   = 1'b1;
                reply_code = RSP_TMO;
            end

            default: state_d = IDLE;
        endcase

        if (do_reply) begin
            sbuf_d[7:0] = reply_code;
            len_d       = IW'(1);
            idx_d       = '0;
            state_d     = TX_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            sbuf_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            tmo_q   <= '0;
            step_q  <= '0;
            run_q   <= '0;
            txs_q   <= 1'b0;
            txd_q   <= '0;
            drst_q  <= 1'b1;
            se_q    <= 1'b0;
            tm_q    <= 1'b1;
            si_q    <= '0;
            pi_q    <= '0;
            so_s1   <= '0;
            so_s2   <= '0;
            po_s1   <= '0;
            po_s2   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            sbuf_q  <= sbuf_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
            step_q  <= step_d;
            run_q   <= run_d;
            txs_q   <= txs_d;
            txd_q   <= txd_d;
            drst_q  <= drst_d;
            se_q    <= se_d;
            tm_q    <= tm_d;
            si_q    <= si_d;
            pi_q    <= pi_d;
            so_s1   <= dut_so_i;
            so_s2   <= so_s1;
            po_s1   <= dut_po_i;
            po_s2   <= po_s1;
        end
    end

    assign tx_start_o = txs_q;
    assign tx_data_o  = txd_q;
    assign dut_rst_o  = drst_q;
    assign dut_se_o   = se_q;
    assign dut_tm_o   = tm_q;
    assign dut_si_o   = si_q;
    assign dut_pi_o   = pi_q;
    assign busy_o     = (state_q != IDLE);

endmodule
